// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array sequencer: state encoding and phase-length helpers.
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_W    = 3'd1,
        S_LD_A    = 3'd2,
        S_FILL    = 3'd3,
        S_CAPTURE = 3'd4,
        S_UNLOAD  = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    function automatic int fill_len(input int cols, input int dsp_delay);
        return cols * dsp_delay;
    endfunction

    function automatic int capture_len(input int rows, input int dsp_delay);
        return dsp_delay * (rows - 1) + rows;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed for a counter running 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_ROWS  = 16;
    localparam int DEF_COLS  = 16;
    localparam int DEF_ROW_W = width_for(DEF_ROWS);
    localparam int DEF_CNT_W = width_for(max_int(fill_len(DEF_COLS, 1), capture_len(DEF_ROWS, 1)));

endpackage

// File: rtl/systolic_seq_ctrl.sv
// Start/done sequencer for the systolic array; outputs are registered and follow the deciding edge by one cycle.
// No backpressure: start is only accepted in IDLE, abort returns to IDLE on the next edge.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int DSP_DELAY = 1,
    parameter int TILE_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [TILE_W-1:0]       num_tiles,
    input  logic                    reuse_weight,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [TILE_W-1:0]       tile_idx,
    output logic [$clog2(ROWS)-1:0] row_idx,
    output logic                    weight_buffer_load_en,
    output logic                    weight_buffer_out_en,
    output logic                    write_weight_en,
    output logic                    input_buffer_load_en,
    output logic                    input_buffer_out_en,
    output logic                    output_buffer_load_en,
    output logic                    output_buffer_out_en
);

    localparam int FILL_LEN = fill_len(COLS, DSP_DELAY);
    localparam int CAP_LEN  = capture_len(ROWS, DSP_DELAY);
    localparam int CW       = width_for(max_int(max_int(FILL_LEN, CAP_LEN), ROWS));
    localparam int RW       = $clog2(ROWS);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, last_cnt;
    logic [TILE_W-1:0] tile_d, num_q, num_d;
    logic              reuse_q, reuse_d, phase_end;

    logic              busy_d, done_d, in_rows_d, reuse_tile_d;
    logic [RW-1:0]     row_idx_d;

    always_comb begin
        case (state_q)
            S_LD_W, S_LD_A, S_UNLOAD: last_cnt = CW'(ROWS - 1);
            S_FILL:                   last_cnt = CW'(FILL_LEN - 1);
            S_CAPTURE:                last_cnt = CW'(CAP_LEN - 1);
            default:                  last_cnt = '0;
        endcase
        phase_end = (cnt_q == last_cnt);

        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        tile_d  = tile_idx;
        num_d   = num_q;
        reuse_d = reuse_q;

        if (abort) begin
            state_d = S_IDLE;
            tile_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_d   = num_tiles;
                        reuse_d = reuse_weight;
                        tile_d  = '0;
                        state_d = (num_tiles == '0) ? S_DONE : S_LD_W;
                    end
                end
                S_LD_W:    if (phase_end) state_d = S_LD_A;
                S_LD_A:    if (phase_end) state_d = S_FILL;
                S_FILL:    if (phase_end) state_d = S_CAPTURE;
                S_CAPTURE: if (phase_end) state_d = S_UNLOAD;
                S_UNLOAD: begin
                    if (phase_end) begin
                        // Compare against num-1 so a full-scale tile count never wraps tile_idx.
                        if (tile_idx == num_q - TILE_W'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            tile_d  = tile_idx + TILE_W'(1);
                            state_d = reuse_q ? S_LD_A : S_LD_W;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    end

    // Outputs are decoded from next state so that the registered copies line up with state_q.
    always_comb begin
        in_rows_d    = (state_d inside {S_LD_W, S_LD_A, S_UNLOAD});
        reuse_tile_d = reuse_d && (tile_d != '0);
        busy_d       = !(state_d inside {S_IDLE, S_DONE});
        done_d       = (state_d == S_DONE);
        row_idx_d    = in_rows_d ? cnt_d[RW-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q               <= S_IDLE;
            cnt_q                 <= '0;
            num_q                 <= '0;
            reuse_q               <= 1'b0;
            tile_idx              <= '0;
            row_idx               <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            weight_buffer_load_en <= 1'b0;
            weight_buffer_out_en  <= 1'b0;
            write_weight_en       <= 1'b0;
            input_buffer_load_en  <= 1'b0;
            input_buffer_out_en   <= 1'b0;
            output_buffer_load_en <= 1'b0;
            output_buffer_out_en  <= 1'b0;
        end else begin
            state_q               <= state_d;
            cnt_q                 <= cnt_d;
            num_q                 <= num_d;
            reuse_q               <= reuse_d;
            tile_idx              <= tile_d;
            row_idx               <= row_idx_d;
            busy                  <= busy_d;
            done                  <= done_d;
            weight_buffer_load_en <= (state_d == S_LD_W);
            weight_buffer_out_en  <= (state_d == S_LD_A) && !reuse_tile_d;
            write_weight_en       <= (state_d == S_LD_A) && !reuse_tile_d;
            input_buffer_load_en  <= (state_d == S_LD_A);
            input_buffer_out_en   <= (state_d inside {S_FILL, S_CAPTURE, S_UNLOAD});
            output_buffer_load_en <= (state_d == S_CAPTURE);
            output_buffer_out_en  <= (state_d == S_UNLOAD);
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl at default parameters: job table plus abort/reset corner cases.
module tb_systolic_seq_ctrl;
    import systolic_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_tiles = '0;
    logic       reuse_weight = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done;
    logic [7:0] tile_idx;
    logic [3:0] row_idx;
    logic       wl_en, wo_en, ww_en, il_en, io_en, ol_en, oo_en;
    logic [6:0] en;
    logic [20:0] all_out;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign en      = {wl_en, wo_en, ww_en, il_en, io_en, ol_en, oo_en};
    assign all_out = {busy, done, tile_idx, row_idx, en};

    systolic_seq_ctrl #(.ROWS(16), .COLS(16), .DSP_DELAY(1), .TILE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles),
        .reuse_weight(reuse_weight), .abort(abort), .busy(busy), .done(done),
        .tile_idx(tile_idx), .row_idx(row_idx),
        .weight_buffer_load_en(wl_en), .weight_buffer_out_en(wo_en),
        .write_weight_en(ww_en), .input_buffer_load_en(il_en),
        .input_buffer_out_en(io_en), .output_buffer_load_en(ol_en),
        .output_buffer_out_en(oo_en)
    );

    typedef struct {
        int n; bit r; int poke;
        int done_cyc; int wl; int wo; int ww; int il; int io; int ol; int oo;
        int busy_cnt; int first_ol; int rowsum; int maxtile;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts one job, counts enable cycles per output, and checks totals against the record.
    task automatic run_vec(input int idx, input vec_t v);
        int cyc, done_cyc, ndone, first_ol, rowsum, maxtile, limit;
        int c_wl, c_wo, c_ww, c_il, c_io, c_ol, c_oo, c_busy;
        string p;
        cyc = 1; done_cyc = 0; ndone = 0; first_ol = 0; rowsum = 0; maxtile = 0;
        c_wl = 0; c_wo = 0; c_ww = 0; c_il = 0; c_io = 0; c_ol = 0; c_oo = 0; c_busy = 0;
        limit = v.done_cyc + 20;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        num_tiles = v.n[7:0]; reuse_weight = v.r; start = 1'b1;
        @(negedge clk);
        start = 1'b0; num_tiles = 8'd7; reuse_weight = ~v.r;
        while (cyc <= limit) begin
            c_wl += wl_en; c_wo += wo_en; c_ww += ww_en; c_il += il_en;
            c_io += io_en; c_ol += ol_en; c_oo += oo_en; c_busy += busy;
            rowsum += row_idx;
            if (tile_idx > maxtile) maxtile = tile_idx;
            if (ol_en && first_ol == 0) first_ol = cyc;
            if (done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (done_cyc != 0 && cyc >= done_cyc + 4) break;
            if (cyc == v.poke) begin
                start = 1'b1; num_tiles = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({p, "_done_cyc"}, done_cyc, v.done_cyc);
        chk({p, "_ndone"}, ndone, 1);
        chk({p, "_wload"}, c_wl, v.wl);
        chk({p, "_wout"}, c_wo, v.wo);
        chk({p, "_wwrite"}, c_ww, v.ww);
        chk({p, "_iload"}, c_il, v.il);
        chk({p, "_iout"}, c_io, v.io);
        chk({p, "_oload"}, c_ol, v.ol);
        chk({p, "_oout"}, c_oo, v.oo);
        chk({p, "_busy"}, c_busy, v.busy_cnt);
        chk({p, "_first_oload"}, first_ol, v.first_ol);
        chk({p, "_rowsum"}, rowsum, v.rowsum);
        chk({p, "_maxtile"}, maxtile, v.maxtile);
    endtask

    initial begin
        int cyc, dcount, bcount;

        //           n    r  poke done   wl  wo  ww  il    io     ol    oo    busy   fol rowsum maxt
        vecs[0] = '{  1, 1'b0,  0,    96, 16, 16, 16,   16,    63,   31,   16,    95, 49,   360,   0};
        vecs[1] = '{  3, 1'b1,  0,   254, 16, 16, 16,   48,   189,   93,   48,   253, 49,   840,   2};
        vecs[2] = '{  0, 1'b0,  0,     1,  0,  0,  0,    0,     0,    0,    0,     0,  0,     0,   0};
        vecs[3] = '{  2, 1'b0, 60,   191, 32, 32, 32,   32,   126,   62,   32,   190, 49,   720,   1};
        vecs[4] = '{  2, 1'b1,  0,   175, 16, 16, 16,   32,   126,   62,   32,   174, 49,   600,   1};
        vecs[5] = '{255, 1'b1,  0, 20162, 16, 16, 16, 4080, 16065, 7905, 4080, 20161, 49, 61320, 254};

        #12;
        chk("reset_outputs", int'(all_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", int'(all_out), 0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // abort together with start in IDLE: start dropped
        @(negedge clk);
        start = 1'b1; abort = 1'b1; num_tiles = 8'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_outputs", int'(all_out), 0);
        bcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bcount += busy + done;
        end
        chk("abort_start_quiet", bcount, 0);

        // abort sampled at the end of cycle 40 (FILL)
        @(negedge clk);
        num_tiles = 8'd1; reuse_weight = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc < 40; cyc++) @(negedge clk);
        chk("abort_pre_fill_iout", int'(io_en), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_enables", int'(en), 0);
        chk("abort_busy", int'(busy), 0);
        dcount = 0;
        for (int i = 0; i < 120; i++) begin
            dcount += done + busy + (en != 0);
            @(negedge clk);
        end
        chk("abort_no_done", dcount, 0);
        run_vec(6, vecs[0]);

        // asynchronous reset in cycle 60
        @(negedge clk);
        num_tiles = 8'd1; reuse_weight = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc < 60; cyc++) @(negedge clk);
        chk("rst_pre_busy", int'(busy), 1);
        chk("rst_pre_oload", int'(ol_en), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", int'(all_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(7, vecs[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
